// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline control logic: hazard FSM states,
// forwarding mux encodings and instruction register-field positions.
package core_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;

endpackage

// File: rtl/fwd_sel_unit.sv
// Per-operand bypass select: picks the youngest in-flight producer of rs.
import core_pkg::*;

module fwd_sel_unit (
    input  logic [4:0] rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwen,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwen,
    output logic [1:0] fwd_sel
);

    // x0 never forwards; MEM result is younger than WB so it wins
    always_comb begin
        fwd_sel = FWD_RF;
        if (rs == 5'd0) begin
            fwd_sel = FWD_RF;
        end else if (mem_regwen && (mem_rd == rs)) begin
            fwd_sel = FWD_MEM;
        end else if (wb_regwen && (wb_rd == rs)) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, redirect flushes, operand forwarding
// selects and saturating stall/flush performance counters.
import core_pkg::*;

module hazard_ctrl #(
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_ins,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwen,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwen,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwen,
    input  logic             ex_redirect,
    input  logic             perf_clr,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0] LL_RELOAD = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;
    localparam logic [2:0] FL_RELOAD = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [4:0] rs1_s, rs2_s;
    logic       hz_s;
    logic       unused_ins_s;

    hz_state_e  state_r, state_nxt_s;
    logic [2:0] cnt_r, cnt_nxt_s;
    logic       stall_s, flush_s, flush_inc_s;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

    assign rs1_s        = id_ins[RS1_MSB:RS1_LSB];
    assign rs2_s        = id_ins[RS2_MSB:RS2_LSB];
    assign unused_ins_s = ^{id_ins[31:25], id_ins[14:0]};

    assign hz_s = ex_memread && ex_regwen && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (rs1_s == ex_rd)) || (id_use_rs2 && (rs2_s == ex_rd)));

    fwd_sel_unit u_fwd_a (
        .rs(rs1_s), .mem_rd(mem_rd), .mem_regwen(mem_regwen),
        .wb_rd(wb_rd), .wb_regwen(wb_regwen), .fwd_sel(fwd_a_sel)
    );

    fwd_sel_unit u_fwd_b (
        .rs(rs2_s), .mem_rd(mem_rd), .mem_regwen(mem_regwen),
        .wb_rd(wb_rd), .wb_regwen(wb_regwen), .fwd_sel(fwd_b_sel)
    );

    // FSM next state and control outputs; a redirect always preempts a stall
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stall_s     = 1'b0;
        flush_s     = 1'b0;
        flush_inc_s = 1'b0;
        case (state_r)
            ST_RUN, ST_STALL: begin
                if (ex_redirect) begin
                    flush_s     = 1'b1;
                    flush_inc_s = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt_s = ST_FLUSH;
                        cnt_nxt_s   = FL_RELOAD;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else if (state_r == ST_STALL) begin
                    stall_s = 1'b1;
                    if (cnt_r == 3'd0) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        cnt_nxt_s = cnt_r - 3'd1;
                    end
                end else if (hz_s) begin
                    stall_s = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_nxt_s = ST_STALL;
                        cnt_nxt_s   = LL_RELOAD;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                flush_s = 1'b1;
                if (ex_redirect) begin
                    flush_inc_s = 1'b1;
                    cnt_nxt_s   = FL_RELOAD;
                end else if (cnt_r == 3'd0) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    cnt_nxt_s = cnt_r - 3'd1;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    // FSM state and down-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Saturating performance counters; clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (perf_clr) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (flush_inc_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
        end
    end

    assign stall_if  = stall_s;
    assign stall_id  = stall_s;
    assign flush_id  = flush_s;
    assign flush_ex  = flush_s | stall_s;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instance A (LOAD_LAT=1, FLUSH_CYCLES=2, CNT_W=32)
// and instance B (LOAD_LAT=3, FLUSH_CYCLES=2, CNT_W=4) share one stimulus stream.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_ins;
    logic        id_use_rs1, id_use_rs2;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_regwen, ex_memread, mem_regwen, wb_regwen;
    logic        ex_redirect, perf_clr;

    logic        a_stall_if, a_stall_id, a_flush_id, a_flush_ex;
    logic [1:0]  a_fwd_a, a_fwd_b;
    logic [31:0] a_stall_cnt, a_flush_cnt;
    logic        b_stall_if, b_stall_id, b_flush_id, b_flush_ex;
    logic [1:0]  b_fwd_a, b_fwd_b;
    logic [3:0]  b_stall_cnt, b_flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LAT(1), .FLUSH_CYCLES(2), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_ins(id_ins),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_regwen(ex_regwen), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwen(mem_regwen), .wb_rd(wb_rd), .wb_regwen(wb_regwen),
        .ex_redirect(ex_redirect), .perf_clr(perf_clr),
        .stall_if(a_stall_if), .stall_id(a_stall_id), .flush_id(a_flush_id), .flush_ex(a_flush_ex),
        .fwd_a_sel(a_fwd_a), .fwd_b_sel(a_fwd_b), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_ins(id_ins),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_regwen(ex_regwen), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwen(mem_regwen), .wb_rd(wb_rd), .wb_regwen(wb_regwen),
        .ex_redirect(ex_redirect), .perf_clr(perf_clr),
        .stall_if(b_stall_if), .stall_id(b_stall_id), .flush_id(b_flush_id), .flush_ex(b_flush_ex),
        .fwd_a_sel(b_fwd_a), .fwd_b_sel(b_fwd_b), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    function automatic logic [31:0] mk_ins(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, 5'd0, 7'b0110011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_ins = 32'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_regwen = 1'b0; ex_memread = 1'b0;
        mem_rd = 5'd0; mem_regwen = 1'b0; wb_rd = 5'd0; wb_regwen = 1'b0;
        ex_redirect = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_rd = rd; ex_regwen = 1'b1; ex_memread = 1'b1;
        id_ins = mk_ins(rd, 5'd1); id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_a_stall_if", 32'(a_stall_if), 32'd0);
        chk("rst_a_flush_ex", 32'(a_flush_ex), 32'd0);
        chk("rst_b_flush_id", 32'(b_flush_id), 32'd0);
        chk("rst_a_stall_cnt", a_stall_cnt, 32'd0);
        chk("rst_b_flush_cnt", 32'(b_flush_cnt), 32'd0);
        #11 rst_n = 1'b1;
        step();

        // 1: lw x5 in EX, add x6,x5,x1 in ID
        set_load_use(5'd5);
        #1;
        chk("t1_stall_if", 32'(a_stall_if), 32'd1);
        chk("t1_stall_id", 32'(a_stall_id), 32'd1);
        chk("t1_flush_ex", 32'(a_flush_ex), 32'd1);
        chk("t1_flush_id", 32'(a_flush_id), 32'd0);
        step();
        ex_rd = 5'd0; ex_regwen = 1'b0; ex_memread = 1'b0;
        mem_rd = 5'd5; mem_regwen = 1'b1;
        #1;
        chk("t1_stall_drop", 32'(a_stall_if), 32'd0);
        chk("t1_fwd_a", 32'(a_fwd_a), 32'd1);
        chk("t1_fwd_b", 32'(a_fwd_b), 32'd0);
        chk("t1_stall_cnt", a_stall_cnt, 32'd1);

        // 2: forwarding priority and x0
        clear_inputs();
        mem_rd = 5'd7; mem_regwen = 1'b1; wb_rd = 5'd7; wb_regwen = 1'b1;
        id_ins = mk_ins(5'd3, 5'd7);
        #1;
        chk("t2_fwd_b_mem", 32'(a_fwd_b), 32'd1);
        chk("t2_fwd_a_rf", 32'(a_fwd_a), 32'd0);
        mem_regwen = 1'b0;
        #1;
        chk("t2_fwd_b_wb", 32'(a_fwd_b), 32'd2);
        mem_rd = 5'd0; mem_regwen = 1'b1; wb_rd = 5'd0; wb_regwen = 1'b1;
        id_ins = mk_ins(5'd0, 5'd0);
        #1;
        chk("t2_fwd_b_x0", 32'(a_fwd_b), 32'd0);
        chk("t2_fwd_a_x0", 32'(a_fwd_a), 32'd0);
        set_load_use(5'd0);
        #1;
        chk("t2_no_hz_x0", 32'(a_stall_if), 32'd0);
        set_load_use(5'd9);
        id_use_rs1 = 1'b0;
        #1;
        chk("t2_no_hz_unused", 32'(a_stall_if), 32'd0);

        // 3: redirect pulse, two flush cycles
        do_reset();
        ex_redirect = 1'b1;
        #1;
        chk("t3_flush_id_c1", 32'(a_flush_id), 32'd1);
        chk("t3_flush_ex_c1", 32'(a_flush_ex), 32'd1);
        chk("t3_stall_c1", 32'(a_stall_if), 32'd0);
        step();
        ex_redirect = 1'b0;
        #1;
        chk("t3_flush_id_c2", 32'(a_flush_id), 32'd1);
        chk("t3_flush_ex_c2", 32'(a_flush_ex), 32'd1);
        step();
        chk("t3_flush_id_c3", 32'(a_flush_id), 32'd0);
        chk("t3_flush_ex_c3", 32'(a_flush_ex), 32'd0);
        chk("t3_flush_cnt", a_flush_cnt, 32'd1);

        // 4: LOAD_LAT=3, redirect in 2nd stall cycle
        do_reset();
        set_load_use(5'd5);
        #1;
        chk("t4_stall_c1", 32'(b_stall_if), 32'd1);
        step();
        ex_redirect = 1'b1;
        #1;
        chk("t4_stall_c2", 32'(b_stall_if), 32'd0);
        chk("t4_stall_id_c2", 32'(b_stall_id), 32'd0);
        chk("t4_flush_id_c2", 32'(b_flush_id), 32'd1);
        chk("t4_flush_ex_c2", 32'(b_flush_ex), 32'd1);
        step();
        clear_inputs();
        #1;
        chk("t4_flush_id_c3", 32'(b_flush_id), 32'd1);
        chk("t4_stall_c3", 32'(b_stall_if), 32'd0);
        step();
        chk("t4_flush_id_c4", 32'(b_flush_id), 32'd0);
        chk("t4_stall_cnt", 32'(b_stall_cnt), 32'd1);
        chk("t4_flush_cnt", 32'(b_flush_cnt), 32'd1);

        // 5: hazard and redirect together
        do_reset();
        set_load_use(5'd5);
        ex_redirect = 1'b1;
        #1;
        chk("t5_stall_if", 32'(a_stall_if), 32'd0);
        chk("t5_stall_id", 32'(a_stall_id), 32'd0);
        chk("t5_flush_id", 32'(a_flush_id), 32'd1);
        step();
        clear_inputs();
        #1;
        chk("t5_flush_cnt", a_flush_cnt, 32'd1);
        chk("t5_stall_cnt", a_stall_cnt, 32'd0);
        chk("t5_in_flush", 32'(a_flush_id), 32'd1);

        // 6a: asynchronous reset during FLUSH
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_flush_id", 32'(a_flush_id), 32'd0);
        chk("t6_rst_flush_ex", 32'(a_flush_ex), 32'd0);
        chk("t6_rst_flush_cnt", a_flush_cnt, 32'd0);
        step();
        rst_n = 1'b1;

        // 6b: stall counter saturation and clear priority
        step();
        set_load_use(5'd5);
        repeat (20) step();
        chk("t6_b_stall_sat", 32'(b_stall_cnt), 32'd15);
        chk("t6_a_stall_20", a_stall_cnt, 32'd20);
        step();
        chk("t6_b_stall_hold", 32'(b_stall_cnt), 32'd15);
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        chk("t6_b_clr_stall", 32'(b_stall_cnt), 32'd0);
        chk("t6_a_clr_stall", a_stall_cnt, 32'd0);

        // 6c: flush counter saturation on back-to-back redirects
        clear_inputs();
        ex_redirect = 1'b1;
        repeat (17) step();
        chk("t6_b_flush_sat", 32'(b_flush_cnt), 32'd15);
        chk("t6_a_flush_17", a_flush_cnt, 32'd17);
        perf_clr = 1'b1;
        step();
        clear_inputs();
        chk("t6_b_clr_flush", 32'(b_flush_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
